// File: rtl/uart_sim_transmitter.sv
// Byte-wide UART transmitter with a small transmit FIFO, paced by a shared 16x oversample tick.
// Frames are 1 start, 8 data (LSB first) and 1 stop bit, each held for 16 ticks.
module uart_sim_transmitter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_50m,
  input  logic       rst_n,
  input  logic       clken,
  input  logic       wr_en,
  input  logic [7:0] din,
  output logic       full,
  output logic       ovf,
  output logic       busy,
  output logic       tx
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [1:0]    state_q, state_d;
  logic [3:0]    tick_q, tick_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;

  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  // Full/empty come only from the registered count, so a pop in the same
  // cycle never lets a write slip into a full FIFO.
  assign fifo_full  = (count_q == DEPTH_C);
  assign fifo_empty = (count_q == '0);
  assign push       = wr_en && !fifo_full;

  assign full = fifo_full;
  assign ovf  = wr_en && fifo_full;
  assign tx   = tx_q;
  assign busy = busy_q;

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;

    if (clken) begin
      case (state_q)
        ST_IDLE: begin
          tx_d = 1'b1;
          if (!fifo_empty) begin
            pop       = 1'b1;
            shift_d   = mem_q[rd_ptr_q];
            tick_d    = 4'd0;
            bit_idx_d = 3'd0;
            state_d   = ST_START;
            tx_d      = 1'b0;
          end
        end

        ST_START: begin
          tick_d = tick_q + 4'd1;
          if (tick_q == 4'd15) begin
            state_d   = ST_DATA;
            bit_idx_d = 3'd0;
            tx_d      = shift_q[0];
          end
        end

        // The shift register moves right so the outgoing bit is always bit 0.
        ST_DATA: begin
          tick_d = tick_q + 4'd1;
          if (tick_q == 4'd15) begin
            if (bit_idx_q == 3'd7) begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
              shift_d   = {1'b0, shift_q[7:1]};
              tx_d      = shift_q[1];
            end
          end
        end

        ST_STOP: begin
          tick_d = tick_q + 4'd1;
          if (tick_q == 4'd15) begin
            if (!fifo_empty) begin
              pop       = 1'b1;
              shift_d   = mem_q[rd_ptr_q];
              tick_d    = 4'd0;
              bit_idx_d = 3'd0;
              state_d   = ST_START;
              tx_d      = 1'b0;
            end else begin
              state_d = ST_IDLE;
              tx_d    = 1'b1;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    busy_d = (state_d != ST_IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk_50m) begin
    if (push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= ST_IDLE;
      tick_q    <= 4'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_sim_transmitter.sv
// Self-checking bench for uart_sim_transmitter: directed scenarios plus random traffic,
// compared every cycle against a queue-based model of the serial line.
module tb_uart_sim_transmitter;

  localparam int DEPTH = 4;

  logic       clk_50m = 1'b0;
  logic       rst_n   = 1'b1;
  logic       clken   = 1'b0;
  logic       wr_en   = 1'b0;
  logic [7:0] din     = 8'h00;
  logic       full;
  logic       ovf;
  logic       busy;
  logic       tx;

  int checks = 0;
  int errors = 0;

  // Reference model: bytes waiting, plus the tick-by-tick line levels of the frame in flight.
  byte unsigned fifoQ[$];
  bit           tickQ[$];
  bit           inFrame = 1'b0;
  bit           expTx   = 1'b1;

  uart_sim_transmitter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_50m(clk_50m),
    .rst_n  (rst_n),
    .clken  (clken),
    .wr_en  (wr_en),
    .din    (din),
    .full   (full),
    .ovf    (ovf),
    .busy   (busy),
    .tx     (tx)
  );

  always #5 clk_50m = ~clk_50m;

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b time=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic loadFrame(input byte unsigned b);
    for (int k = 0; k < 16; k++) tickQ.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 16; k++) tickQ.push_back(b[i]);
    for (int k = 0; k < 16; k++) tickQ.push_back(1'b1);
  endtask

  // Applies one rising edge to the model; admission uses the occupancy before the edge.
  task automatic modelStep(input bit wr, input byte unsigned d, input bit ce);
    bit           accept;
    byte unsigned b;
    accept = wr && (fifoQ.size() < DEPTH);
    if (ce) begin
      if (tickQ.size() == 0) begin
        if (fifoQ.size() != 0) begin
          b = fifoQ.pop_front();
          loadFrame(b);
          inFrame = 1'b1;
        end else begin
          inFrame = 1'b0;
        end
      end
      if (tickQ.size() != 0) expTx = tickQ.pop_front();
      else                   expTx = 1'b1;
    end
    if (accept) fifoQ.push_back(d);
  endtask

  task automatic modelReset();
    fifoQ.delete();
    tickQ.delete();
    inFrame = 1'b0;
    expTx   = 1'b1;
  endtask

  // Called just after a rising edge; drives one full clock cycle and checks around it.
  task automatic applyStimulus(input bit wr, input byte unsigned d, input bit ce);
    wr_en = wr;
    din   = d;
    clken = ce;
    @(negedge clk_50m);
    checkOutput("full", full, fifoQ.size() == DEPTH);
    checkOutput("ovf", ovf, wr && (fifoQ.size() == DEPTH));
    @(posedge clk_50m);
    modelStep(wr, d, ce);
    #1;
    checkOutput("tx", tx, expTx);
    checkOutput("busy", busy, inFrame || (fifoQ.size() != 0));
  endtask

  task automatic idleCycles(input int n, input bit ce);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'($urandom), ce);
  endtask

  task automatic doReset();
    wr_en = 1'b0;
    clken = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_tx", tx, 1'b1);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_full", full, 1'b0);
    checkOutput("rst_ovf", ovf, 1'b0);
    modelReset();
    @(posedge clk_50m);
    @(negedge clk_50m);
    rst_n = 1'b1;
    @(posedge clk_50m);
    modelStep(1'b0, 8'h00, 1'b0);
    #1;
  endtask

  initial begin
    bit wr;
    bit ce;

    #1 rst_n = 1'b0;
    #1;
    checkOutput("init_tx", tx, 1'b1);
    checkOutput("init_busy", busy, 1'b0);
    checkOutput("init_full", full, 1'b0);
    checkOutput("init_ovf", ovf, 1'b0);
    @(negedge clk_50m);
    rst_n = 1'b1;
    @(posedge clk_50m);
    #1;

    $display("[TB] single byte 0x55, tick every cycle");
    applyStimulus(1'b1, 8'h55, 1'b1);
    idleCycles(175, 1'b1);

    $display("[TB] back-to-back 0xA5, 0x3C");
    applyStimulus(1'b1, 8'hA5, 1'b1);
    applyStimulus(1'b1, 8'h3C, 1'b1);
    idleCycles(330, 1'b1);

    $display("[TB] five writes with tick stopped");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'($urandom), 1'b0);
    idleCycles(5, 1'b0);
    idleCycles(4 * 160 + 20, 1'b1);

    $display("[TB] tick every third cycle");
    applyStimulus(1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 3 * 165; i++) applyStimulus(1'b0, 8'h00, (i % 3) == 2);

    $display("[TB] reset during a data bit with two bytes queued");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'($urandom), 1'b1);
    idleCycles(70, 1'b1);
    doReset();
    idleCycles(200, 1'b1);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      if (i == 2200) doReset();
      wr = ($urandom_range(0, 7) == 0);
      ce = (i < 1500) ? 1'b1 : 1'($urandom_range(0, 1));
      applyStimulus(wr, 8'($urandom), ce);
    end
    idleCycles(20, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_sim_transmitter.md
UART_SIM_TRANSMITTER -- requirements
Module: uart_sim_transmitter

Interface
REQ-001 SHALL have parameter: FIFO_DEPTH, 4, transmit FIFO entries (power of two, min 2).
REQ-002 SHALL have port: clk_50m  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port: clken  input  1  16x-baud oversample tick; the same tick that drives the companion receiver.
REQ-005 SHALL have port: wr_en  input  1  push din into FIFO.
REQ-006 SHALL have port: din  input  8  byte to transmit.
REQ-007 SHALL have port: full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-008 SHALL have port: ovf  output  1  one-cycle pulse on a rejected write.
REQ-009 SHALL have port: busy  output  1  FIFO non-empty or frame in progress.
REQ-010 SHALL have port: tx  output  1  serial line, idle high, registered.

Function
REQ-011 SHALL accept a write when wr_en=1 and full=0, storing din at the tail; count increments next edge.
REQ-012 SHALL ignore wr_en=1 while registered full=1, even if a pop occurs the same cycle, and SHALL pulse ovf for exactly that cycle.
REQ-013 SHALL derive full and empty from the registered count (0..FIFO_DEPTH); simultaneous push and pop SHALL leave count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP; FSM and 4-bit tick counter SHALL advance only on cycles with clken=1 and hold otherwise.
REQ-015 IDLE: tx=1; on clken with FIFO non-empty SHALL pop head into shift register, clear tick counter, enter START.
REQ-016 START: tx=0 for 16 clken ticks; on tick 15 SHALL enter DATA with bit index 0.
REQ-017 DATA: tx=shift-register bit, LSB first, each bit held 16 ticks; after bit 7 tick 15 SHALL enter STOP.
REQ-018 STOP: tx=1 for 16 ticks; on tick 15, if FIFO non-empty SHALL pop and enter START directly, with no idle ticks; otherwise enter IDLE.
REQ-019 Frame length SHALL be exactly 160 clken ticks: 1 start, 8 data, 1 stop.
REQ-020 tx SHALL be a register updated on the same edge as the state transition; no combinational path from wr_en, din or clken to tx.
REQ-021 Latency: write at edge N into empty FIFO while IDLE -> tx falls on the first clken edge after N (earliest N+1).
REQ-022 busy SHALL equal (state != IDLE) OR (count != 0), registered.
REQ-023 Writes SHALL be accepted normally while clken=0 or mid-frame.

Reset
REQ-024 rst_n=0 SHALL immediately force tx=1, busy=0, full=0, ovf=0, state=IDLE, tick counter=0, bit index=0, count=0, and FIFO pointers=0.
REQ-025 Reset mid-frame SHALL abort the frame and discard all FIFO contents; after release, no byte SHALL be sent until a new write.
REQ-026 FIFO storage contents need not be reset.

Verification
REQ-027 clken=1 every cycle, write 0x55 -> tx 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), each 16 cycles; busy low after 160 ticks.
REQ-028 Loopback tx into the uart_sim_receiver with a shared clken, write 0xA5 -> receiver rdy=1, data=0xA5.
REQ-029 Write 0xA5 then 0x3C back-to-back -> 320 contiguous ticks, second start bit immediately after first stop, tx never idle between frames.
REQ-030 clken=0, write 5 bytes, FIFO_DEPTH=4 -> full=1 after 4th write, ovf pulses once on the 5th, and only 4 frames are sent once clken resumes.
REQ-031 clken every 3rd cycle -> each bit lasts 48 clk_50m cycles; FSM frozen on non-tick cycles.
REQ-032 rst_n low during DATA bit 3 with 2 bytes queued -> tx=1 immediately, busy=0, count=0; no further frames after release.
